// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants for the ID/EX stage: opcodes, the canonical NOP
// and instruction field bit positions.
package id_ex_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding select: x0 reads zero, then MEM, then WB,
// then the register file value.
module fwd_mux (
    input  logic [4:0]  i_rs,
    input  logic [31:0] i_rf_data,
    input  logic        i_mem_we,
    input  logic [4:0]  i_mem_wa,
    input  logic [31:0] i_mem_wd,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_wa,
    input  logic [31:0] i_wb_wd,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_rf_data;
        if (i_rs == 5'd0) begin
            o_data = 32'd0;
        end else if (i_mem_we && (i_mem_wa == i_rs)) begin
            o_data = i_mem_wd;
        end else if (i_wb_we && (i_wb_wa == i_rs)) begin
            o_data = i_wb_wd;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding, load-use
// bubble insertion, downstream stall and branch flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      rd1,
    input  logic [31:0]      rd2,
    input  logic             mem_we,
    input  logic [4:0]       mem_wa,
    input  logic [31:0]      mem_wd,
    input  logic             wb_we,
    input  logic [4:0]       wb_wa,
    input  logic [31:0]      wb_wd,
    input  logic             stall_in,
    input  logic             flush,
    output logic             rf_fwd1,
    output logic             rf_fwd2,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_inst,
    output logic [31:0]      ex_op1,
    output logic [31:0]      ex_op2,
    output logic [4:0]       ex_rd,
    output logic             ex_is_load,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [6:0]  w_opc;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_is_load;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_hz;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    logic             r_ex_valid;
    logic [31:0]      r_ex_pc;
    logic [31:0]      r_ex_inst;
    logic [31:0]      r_ex_op1;
    logic [31:0]      r_ex_op2;
    logic [4:0]       r_ex_rd;
    logic             r_ex_is_load;
    logic [CNT_W-1:0] r_bubble_cnt;

    assign w_opc      = id_inst[OPC_MSB:OPC_LSB];
    assign w_rd       = id_inst[RD_MSB:RD_LSB];
    assign w_rs1      = id_inst[RS1_MSB:RS1_LSB];
    assign w_rs2      = id_inst[RS2_MSB:RS2_LSB];
    assign w_is_load  = (w_opc == OPC_LOAD);
    assign w_uses_rs1 = !((w_opc == OPC_LUI) || (w_opc == OPC_AUIPC) || (w_opc == OPC_JAL));
    assign w_uses_rs2 = (w_opc == OPC_RTYPE) || (w_opc == OPC_STORE) || (w_opc == OPC_BRANCH);

    // Register file write-through select: WB is writing the register being read.
    assign rf_fwd1 = wb_we && (wb_wa == w_rs1) && (w_rs1 != 5'd0);
    assign rf_fwd2 = wb_we && (wb_wa == w_rs2) && (w_rs2 != 5'd0);

    assign w_hz = id_valid && r_ex_valid && r_ex_is_load && (r_ex_rd != 5'd0) &&
                  ((w_uses_rs1 && (w_rs1 == r_ex_rd)) || (w_uses_rs2 && (w_rs2 == r_ex_rd)));

    assign id_stall = (w_hz || stall_in) && !flush;

    fwd_mux u_fwd1 (
        .i_rs      (w_rs1),
        .i_rf_data (rd1),
        .i_mem_we  (mem_we),
        .i_mem_wa  (mem_wa),
        .i_mem_wd  (mem_wd),
        .i_wb_we   (wb_we),
        .i_wb_wa   (wb_wa),
        .i_wb_wd   (wb_wd),
        .o_data    (w_op1)
    );

    fwd_mux u_fwd2 (
        .i_rs      (w_rs2),
        .i_rf_data (rd2),
        .i_mem_we  (mem_we),
        .i_mem_wa  (mem_wa),
        .i_mem_wd  (mem_wd),
        .i_wb_we   (wb_we),
        .i_wb_wa   (wb_wa),
        .i_wb_wd   (wb_wd),
        .o_data    (w_op2)
    );

    // Flush beats stall beats hazard; a bubble leaves pc/operands untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_pc      <= RESET_PC;
            r_ex_inst    <= NOP_INST;
            r_ex_op1     <= 32'd0;
            r_ex_op2     <= 32'd0;
            r_ex_rd      <= 5'd0;
            r_ex_is_load <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_ex_valid   <= 1'b0;
            r_ex_inst    <= NOP_INST;
            r_ex_rd      <= 5'd0;
            r_ex_is_load <= 1'b0;
        end else if (stall_in) begin
            r_ex_valid   <= r_ex_valid;
        end else if (w_hz) begin
            r_ex_valid   <= 1'b0;
            r_ex_inst    <= NOP_INST;
            r_ex_rd      <= 5'd0;
            r_ex_is_load <= 1'b0;
            if (r_bubble_cnt != {CNT_W{1'b1}}) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else begin
            r_ex_valid   <= id_valid;
            r_ex_pc      <= id_pc;
            r_ex_inst    <= id_inst;
            r_ex_op1     <= w_op1;
            r_ex_op2     <= w_op2;
            r_ex_rd      <= w_rd;
            r_ex_is_load <= w_is_load;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_pc      = r_ex_pc;
    assign ex_inst    = r_ex_inst;
    assign ex_op1     = r_ex_op1;
    assign ex_op2     = r_ex_op2;
    assign ex_rd      = r_ex_rd;
    assign ex_is_load = r_ex_is_load;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of single-cycle capture vectors plus
// hand sequences for load-use, stall/flush, counter saturation and reset.
module tb_id_ex_stage;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ADD_3_1_2 = 32'h0020_81B3;
    localparam logic [31:0] ADD_3_0_0 = 32'h0000_01B3;
    localparam logic [31:0] LW_5      = 32'h0000_A283;
    localparam logic [31:0] ADD_6_5_1 = 32'h0012_8333;
    localparam logic [31:0] LUI_5     = 32'h1234_52B7;
    localparam logic [31:0] SW_5      = 32'h0051_2023;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_inst, rd1, rd2;
    logic        mem_we, wb_we;
    logic [4:0]  mem_wa, wb_wa;
    logic [31:0] mem_wd, wb_wd;
    logic        stall_in, flush;

    logic        rf_fwd1, rf_fwd2, id_stall, ex_valid, ex_is_load;
    logic [31:0] ex_pc, ex_inst, ex_op1, ex_op2;
    logic [4:0]  ex_rd;
    logic [15:0] bubble_cnt;

    logic        s_fwd1, s_fwd2, s_stall, s_valid, s_is_load;
    logic [31:0] s_pc, s_inst, s_op1, s_op2;
    logic [4:0]  s_rd;
    logic [1:0]  s_bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .rd1(rd1), .rd2(rd2), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .stall_in(stall_in), .flush(flush),
        .rf_fwd1(rf_fwd1), .rf_fwd2(rf_fwd2), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .rd1(rd1), .rd2(rd2), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .stall_in(stall_in), .flush(flush),
        .rf_fwd1(s_fwd1), .rf_fwd2(s_fwd2), .id_stall(s_stall), .ex_valid(s_valid),
        .ex_pc(s_pc), .ex_inst(s_inst), .ex_op1(s_op1), .ex_op2(s_op2),
        .ex_rd(s_rd), .ex_is_load(s_is_load), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, inst, r1, r2;
        logic        mwe;
        logic [4:0]  mwa;
        logic [31:0] mwd;
        logic        wwe;
        logic [4:0]  wwa;
        logic [31:0] wwd;
        logic        e_fwd1, e_fwd2, e_valid, e_load;
        logic [31:0] e_op1, e_op2;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] r1, input logic [31:0] r2);
        id_valid = v; id_pc = pc; id_inst = inst; rd1 = r1; rd2 = r2;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mwa, input logic [31:0] mwd,
                           input logic wwe, input logic [4:0] wwa, input logic [31:0] wwd);
        mem_we = mwe; mem_wa = mwa; mem_wd = mwd; wb_we = wwe; wb_wa = wwa; wb_wd = wwd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load LW x5 into EX, then present ADD x6,x5,x1 so a load-use hazard fires.
    task automatic load_use(input string tag);
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'h300, LW_5, 32'h100, 32'h0);
        step();
        set_id(1, 32'h304, ADD_6_5_1, 32'hAAAA, 32'h1111);
        #1;
        chk({tag, "_stall"}, {31'd0, id_stall}, 32'd1);
        step();
        chk({tag, "_bubble"}, {31'd0, ex_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1, 32'h100, ADD_3_1_2, 5, 6, 1, 1, 7, 1, 1, 9,          1, 0, 1, 0, 7, 6, 3};
        vecs[1] = '{1, 32'h104, ADD_3_1_2, 5, 6, 0, 1, 7, 1, 1, 9,          1, 0, 1, 0, 9, 6, 3};
        vecs[2] = '{1, 32'h108, ADD_3_1_2, 5, 6, 0, 0, 0, 1, 2, 4,          0, 1, 1, 0, 5, 4, 3};
        vecs[3] = '{1, 32'h10C, ADD_3_1_2, 5, 6, 1, 2, 8, 1, 2, 4,          0, 1, 1, 0, 5, 8, 3};
        vecs[4] = '{1, 32'h110, ADD_3_0_0, 111, 222, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, 1, 0, 0, 0, 3};
        vecs[5] = '{0, 32'h114, ADD_3_1_2, 5, 6, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 5, 6, 3};
        vecs[6] = '{1, 32'h118, LUI_5, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 32'h11, 32'h22, 5};
        vecs[7] = '{1, 32'h11C, LW_5, 32'h100, 32'h77, 0, 0, 0, 0, 0, 0,    0, 0, 1, 1, 32'h100, 0, 5};

        rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
        set_id(0, 0, NOP, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_pc", ex_pc, 32'h2000);
        chk("rst_inst", ex_inst, NOP);
        chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            set_id(vecs[i].valid, vecs[i].pc, vecs[i].inst, vecs[i].r1, vecs[i].r2);
            set_fwd(vecs[i].mwe, vecs[i].mwa, vecs[i].mwd, vecs[i].wwe, vecs[i].wwa, vecs[i].wwd);
            #1;
            chk($sformatf("v%0d_fwd1", i), {31'd0, rf_fwd1}, {31'd0, vecs[i].e_fwd1});
            chk($sformatf("v%0d_fwd2", i), {31'd0, rf_fwd2}, {31'd0, vecs[i].e_fwd2});
            chk($sformatf("v%0d_stall", i), {31'd0, id_stall}, 32'd0);
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
            chk($sformatf("v%0d_inst", i), ex_inst, vecs[i].inst);
            chk($sformatf("v%0d_op1", i), ex_op1, vecs[i].e_op1);
            chk($sformatf("v%0d_op2", i), ex_op2, vecs[i].e_op2);
            chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_load", i), {31'd0, ex_is_load}, {31'd0, vecs[i].e_load});
            $display("vector %0d: inst=%h ex_op1=%h ex_op2=%h", i, vecs[i].inst, ex_op1, ex_op2);
        end

        // LW x5 in EX, ADD x6,x5,x1 in ID: one bubble, then ADD enters forwarded.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'h120, ADD_6_5_1, 32'hAAAA, 32'h1111);
        #1;
        chk("lu_stall", {31'd0, id_stall}, 32'd1);
        step();
        chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bub_inst", ex_inst, NOP);
        chk("lu_bub_rd", {27'd0, ex_rd}, 32'd0);
        chk("lu_bub_load", {31'd0, ex_is_load}, 32'd0);
        chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
        set_fwd(1, 5, 32'h55, 0, 0, 0);
        #1;
        chk("lu_stall_clear", {31'd0, id_stall}, 32'd0);
        step();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_op1", ex_op1, 32'h55);
        chk("lu_add_op2", ex_op2, 32'h1111);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
        chk("lu_cnt_hold", {16'd0, bubble_cnt}, 32'd1);
        $display("load-use: bubble_cnt=%0d ex_op1=%h", bubble_cnt, ex_op1);

        // LW then LUI x5 (no rs use): no hazard.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'h130, LW_5, 32'h100, 0);
        step();
        set_id(1, 32'h134, LUI_5, 0, 0);
        #1;
        chk("lui_stall", {31'd0, id_stall}, 32'd0);
        step();
        chk("lui_valid", {31'd0, ex_valid}, 32'd1);
        chk("lui_inst", ex_inst, LUI_5);

        // LW then invalid ID slot: no hazard.
        set_id(1, 32'h138, LW_5, 32'h100, 0);
        step();
        set_id(0, 32'h13C, ADD_6_5_1, 0, 0);
        #1;
        chk("inv_stall", {31'd0, id_stall}, 32'd0);
        step();

        // Store reading x5 on rs2 after a load: hazard.
        load_use("sw_pre");
        set_id(1, 32'h140, LW_5, 32'h100, 0);
        step();
        set_id(1, 32'h144, SW_5, 0, 0);
        #1;
        chk("sw_stall", {31'd0, id_stall}, 32'd1);
        step();
        chk("sw_bubble", {31'd0, ex_valid}, 32'd0);
        chk("sw_cnt", {16'd0, bubble_cnt}, 32'd3);
        $display("store-use: bubble_cnt=%0d", bubble_cnt);

        // Downstream stall for 3 cycles while a hazard is also pending.
        set_id(1, 32'h150, LW_5, 32'h100, 0);
        step();
        set_id(1, 32'h154, ADD_6_5_1, 32'h1, 32'h2);
        stall_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d_idstall", c), {31'd0, id_stall}, 32'd1);
            step();
            chk($sformatf("st%0d_pc", c), ex_pc, 32'h150);
            chk($sformatf("st%0d_inst", c), ex_inst, LW_5);
            chk($sformatf("st%0d_load", c), {31'd0, ex_is_load}, 32'd1);
            chk($sformatf("st%0d_cnt", c), {16'd0, bubble_cnt}, 32'd3);
        end
        flush = 1'b1;
        #1;
        chk("fl_idstall", {31'd0, id_stall}, 32'd0);
        step();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_inst", ex_inst, NOP);
        chk("fl_cnt", {16'd0, bubble_cnt}, 32'd3);
        stall_in = 1'b0; flush = 1'b0;
        $display("stall/flush: ex_valid=%0d bubble_cnt=%0d", ex_valid, bubble_cnt);

        // Two more hazards: full counter reaches 5, 2-bit counter saturates at 3.
        load_use("sat1");
        load_use("sat2");
        chk("sat_cnt16", {16'd0, bubble_cnt}, 32'd5);
        chk("sat_cnt2", {30'd0, s_bubble_cnt}, 32'd3);
        $display("saturation: cnt16=%0d cnt2=%0d", bubble_cnt, s_bubble_cnt);

        // Asynchronous reset mid-stall with a valid instruction in EX.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'h160, ADD_3_1_2, 5, 6);
        step();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        stall_in = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_pc", ex_pc, 32'h2000);
        chk("arst_inst", ex_inst, NOP);
        chk("arst_cnt", {16'd0, bubble_cnt}, 32'd0);
        $display("async reset: ex_valid=%0d ex_pc=%h", ex_valid, ex_pc);
        #1;
        rst = 1'b0;
        stall_in = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
